// File: rtl/pll_reconfig_pkg.sv
// Shared types and register map for the PLL dynamic-reconfiguration initiator.
package pll_reconfig_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RST_HOLD, LOCK_WAIT} pll_state_e;

   localparam logic [4:0] PLL_ADDR_RATIOI = 5'h00;
   localparam logic [4:0] PLL_ADDR_RATIOF = 5'h01;
   localparam logic [4:0] PLL_ADDR_RATIO0 = 5'h02;
   localparam logic [4:0] PLL_ADDR_RATIO1 = 5'h03;
   localparam logic [4:0] PLL_ADDR_RATIO2 = 5'h04;
   localparam logic [4:0] PLL_ADDR_RATIO3 = 5'h05;
   localparam int PLL_NUM_WRITES = 6;

   function automatic logic [4:0] pll_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    return PLL_ADDR_RATIOI;
         3'd1:    return PLL_ADDR_RATIOF;
         3'd2:    return PLL_ADDR_RATIO0;
         3'd3:    return PLL_ADDR_RATIO1;
         3'd4:    return PLL_ADDR_RATIO2;
         3'd5:    return PLL_ADDR_RATIO3;
         default: return 5'h00;
      endcase
   endfunction
endpackage

// File: rtl/pll_lock_filter.sv
// Lock synchronizer plus consecutive-high filter; clr holds the filter at zero.
module pll_lock_filter #(
   parameter int LOCK_FILTER = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic pll_lock,
   output logic lock_sync,
   output logic lock_ok
);
   localparam int CW = $clog2(LOCK_FILTER + 1);

   logic          sync1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         sync1     <= pll_lock;
         lock_sync <= sync1;
      end
   end

   // Saturates at LOCK_FILTER; any low synchronized sample restarts the run.
   always_ff @(posedge clk) begin
      if (rst || clr || !lock_sync)
         cnt <= '0;
      else if (cnt != CW'(LOCK_FILTER))
         cnt <= cnt + 1'b1;
   end

   assign lock_ok = (cnt == CW'(LOCK_FILTER));
endmodule

// File: rtl/pll_apb_reconfig.sv
// Writes six divider ratios to the PLL over APB, pulses PLL reset, waits for lock.
module pll_apb_reconfig
   import pll_reconfig_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_FILTER  = 4,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_ratioi,
   input  logic [6:0] req_ratiof,
   input  logic [6:0] req_ratio0,
   input  logic [6:0] req_ratio1,
   input  logic [6:0] req_ratio2,
   input  logic [6:0] req_ratio3,
   output logic       apb_rst_n,
   output logic [4:0] apb_addr,
   output logic       apb_sel,
   output logic       apb_en,
   output logic       apb_write,
   output logic [7:0] apb_wdata,
   output logic       pll_rst,
   input  logic       pll_lock,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int HW = $clog2(RST_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   pll_state_e    state;
   logic [2:0]    widx;
   logic [2:0]    nidx;
   logic [6:0]    ratio [PLL_NUM_WRITES];
   logic [HW-1:0] hcnt;
   logic [TW-1:0] tcnt;
   logic          lock_sync;
   logic          lock_ok;

   assign nidx      = widx + 3'd1;
   assign busy      = (state != IDLE);
   assign req_ready = (state == IDLE) && !rst;

   pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != LOCK_WAIT),
      .pll_lock  (pll_lock),
      .lock_sync (lock_sync),
      .lock_ok   (lock_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) apb_rst_n <= 1'b0;
      else     apb_rst_n <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         widx      <= '0;
         hcnt      <= '0;
         tcnt      <= '0;
         for (int i = 0; i < PLL_NUM_WRITES; i++) ratio[i] <= '0;
         apb_addr  <= '0;
         apb_sel   <= 1'b0;
         apb_en    <= 1'b0;
         apb_write <= 1'b0;
         apb_wdata <= '0;
         pll_rst   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               ratio[0]  <= req_ratioi;
               ratio[1]  <= req_ratiof;
               ratio[2]  <= req_ratio0;
               ratio[3]  <= req_ratio1;
               ratio[4]  <= req_ratio2;
               ratio[5]  <= req_ratio3;
               widx      <= '0;
               apb_sel   <= 1'b1;
               apb_write <= 1'b1;
               apb_addr  <= PLL_ADDR_RATIOI;
               apb_wdata <= {1'b0, req_ratioi};
               state     <= SETUP;
            end
            SETUP: begin
               apb_en <= 1'b1;
               state  <= ACCESS;
            end
            ACCESS: if (widx != 3'(PLL_NUM_WRITES - 1)) begin
               widx      <= nidx;
               apb_en    <= 1'b0;
               apb_addr  <= pll_addr(nidx);
               apb_wdata <= {1'b0, ratio[nidx]};
               state     <= SETUP;
            end else begin
               apb_sel   <= 1'b0;
               apb_en    <= 1'b0;
               apb_write <= 1'b0;
               apb_addr  <= '0;
               apb_wdata <= '0;
               pll_rst   <= 1'b1;
               hcnt      <= '0;
               state     <= RST_HOLD;
            end
            RST_HOLD: if (hcnt == HW'(RST_CYCLES - 1)) begin
               pll_rst <= 1'b0;
               tcnt    <= '0;
               state   <= LOCK_WAIT;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
            // The done/err pulse is shown while still busy; IDLE follows one cycle later.
            LOCK_WAIT: if (done || err)
               state <= IDLE;
            else if (lock_ok && lock_sync)
               done <= 1'b1;
            else if (tcnt == TW'(LOCK_TIMEOUT - 1))
               err <= 1'b1;
            else
               tcnt <= tcnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pll_apb_reconfig.sv
// Directed bench: table of reconfiguration requests plus reset and glitch sequences.
module tb_pll_apb_reconfig;
   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_ratioi, req_ratiof, req_ratio0, req_ratio1, req_ratio2, req_ratio3;
   logic       apb_rst_n;
   logic [4:0] apb_addr;
   logic       apb_sel, apb_en, apb_write;
   logic [7:0] apb_wdata;
   logic       pll_rst, pll_lock, busy, done, err;

   int n_vec = 0;
   int n_bad = 0;

   typedef enum int {M_LOCK, M_TIMEOUT, M_GLITCH} mode_e;
   typedef struct {
      logic [6:0] r [6];
      mode_e      mode;
      bit         hold;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   pll_apb_reconfig #(.RST_CYCLES(16), .LOCK_FILTER(4), .LOCK_TIMEOUT(100)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_ratioi(req_ratioi), .req_ratiof(req_ratiof), .req_ratio0(req_ratio0),
      .req_ratio1(req_ratio1), .req_ratio2(req_ratio2), .req_ratio3(req_ratio3),
      .apb_rst_n(apb_rst_n), .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_en(apb_en),
      .apb_write(apb_write), .apb_wdata(apb_wdata), .pll_rst(pll_rst),
      .pll_lock(pll_lock), .busy(busy), .done(done), .err(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive_ratios(input logic [6:0] r [6]);
      req_ratioi = r[0]; req_ratiof = r[1]; req_ratio0 = r[2];
      req_ratio1 = r[3]; req_ratio2 = r[4]; req_ratio3 = r[5];
   endtask

   function automatic logic [15:0] apb_bus();
      return {apb_sel, apb_en, apb_write, apb_addr, apb_wdata};
   endfunction

   task automatic run_txn(input vec_t v);
      logic [6:0] inv [6];
      logic       acc;
      pll_lock  = 1'b0;
      req_valid = 1'b1;
      drive_ratios(v.r);
      chk("ready in idle", {req_ready, busy}, 2'b10);
      step();
      req_valid = v.hold;
      if (v.hold) begin
         for (int k = 0; k < 6; k++) inv[k] = ~v.r[k];
         drive_ratios(inv);
      end
      for (int i = 0; i < 12; i++) begin
         chk("apb write", apb_bus(), {1'b1, 1'(i % 2), 1'b1, 5'(i / 2), 1'b0, v.r[i / 2]});
         chk("write phase busy/ready/pll_rst", {busy, req_ready, pll_rst}, 3'b100);
         step();
      end
      req_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("pll_rst hold", {pll_rst, apb_sel, busy}, 3'b101);
         step();
      end
      chk("pll_rst released", {pll_rst, busy, done, err, apb_bus()}, {4'b0100, 16'h0});
      acc = 1'b0;
      case (v.mode)
         M_LOCK: begin
            repeat (20) begin step(); acc |= done | err; end
            pll_lock = 1'b1;
            repeat (6) begin step(); acc |= done | err; end
         end
         M_GLITCH: begin
            repeat (5) step();
            pll_lock = 1'b1;
            repeat (3) begin step(); acc |= done | err; end
            pll_lock = 1'b0;
            step(); acc |= done | err;
            pll_lock = 1'b1;
            repeat (6) begin step(); acc |= done | err; end
         end
         default: begin
            repeat (99) begin step(); acc |= done | err; end
         end
      endcase
      chk("no early done/err", acc, 1'b0);
      step();
      if (v.mode == M_TIMEOUT)
         chk("err pulse", {err, done, busy, req_ready, pll_rst}, 5'b10100);
      else
         chk("done pulse", {done, err, busy, req_ready}, 4'b1010);
      step();
      chk("back to idle", {done, err, busy, req_ready, pll_rst}, 5'b00010);
      pll_lock = 1'b0;
   endtask

   initial begin
      vecs[0].r = '{7'd0, 7'd3, 7'd1, 7'd7, 7'd7, 7'd7};       vecs[0].mode = M_LOCK;    vecs[0].hold = 1'b0;
      vecs[1].r = '{7'd127, 7'd0, 7'd64, 7'd5, 7'd99, 7'd42};  vecs[1].mode = M_TIMEOUT; vecs[1].hold = 1'b0;
      vecs[2].r = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60}; vecs[2].mode = M_GLITCH;  vecs[2].hold = 1'b0;
      vecs[3].r = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6};       vecs[3].mode = M_LOCK;    vecs[3].hold = 1'b1;

      rst = 1'b1; req_valid = 1'b0; pll_lock = 1'b0;
      drive_ratios(vecs[0].r);
      repeat (3) step();
      chk("reset outputs", {req_ready, busy, apb_rst_n, pll_rst, done, err, apb_bus()}, 22'h0);
      rst = 1'b0;
      step();
      chk("post-reset", {apb_rst_n, req_ready, busy}, 3'b110);

      for (int v = 0; v < 4; v++) run_txn(vecs[v]);

      // Reset during the fourth write's ACCESS phase.
      req_valid = 1'b1;
      drive_ratios(vecs[2].r);
      step();
      req_valid = 1'b0;
      repeat (7) step();
      chk("4th access before reset", apb_bus(), {3'b111, 5'd3, 1'b0, vecs[2].r[3]});
      rst = 1'b1;
      step();
      chk("mid-op reset", {apb_rst_n, pll_rst, busy, req_ready, done, err, apb_bus()}, 22'h0);
      rst = 1'b0;
      step();
      chk("after mid-op reset", {apb_rst_n, req_ready, busy, apb_sel}, 4'b1100);
      run_txn(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
